mem_stage: RTL and testbench



---
 rtl/mem_stage.sv | 102 ++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory-access stage with sized loads/stores over a req/ack data-memory port
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ExMem_valid,
  input  logic [31:0]       ExMem_ALUOut,
  input  logic [31:0]       ExMem_writeData,
  input  logic [4:0]        ExMem_rd,
  input  logic              ExMem_RegWrite,
  input  logic              ExMem_MemToReg,
  input  logic              ExMem_MemRead,
  input  logic              ExMem_MemWrite,
  input  logic [1:0]        ExMem_size,
  input  logic              ExMem_unsigned,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              mem_misalign,
  output logic              MemWB_valid,
  output logic              MemWB_RegWrite,
  output logic              MemWB_WB_MemToReg,
  output logic [4:0]        MemWB_rd,
  output logic [31:0]       MemWB_ALUOut,
  output logic [31:0]       MemWB_readData
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_nx;
  logic mem_op, aligned, l_uns;
  logic [1:0] l_size;
  logic [3:0] be_nx;
  logic [31:0] wdata_nx, ld_data;
  logic [7:0] ld_byte;
  logic [15:0] ld_half;
  always_comb begin
    mem_op = ExMem_valid & (ExMem_MemRead | ExMem_MemWrite);
    aligned = ExMem_size == 2'b00 ? 1'b1 : ExMem_size == 2'b01 ? ~ExMem_ALUOut[0] : ExMem_ALUOut[1:0] == 2'b00;
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : state_nx;
  always_comb state_nx = state == IDLE ? (mem_op & aligned ? ACCESS : IDLE) : (dmem_ack ? IDLE : ACCESS);
  always_comb begin
    mem_stall = rst_n & (state == IDLE ? mem_op & aligned : ~dmem_ack);
    mem_misalign = rst_n & (state == IDLE) & mem_op & ~aligned;
  end
  always_comb begin
    be_nx = ExMem_size == 2'b00 ? 4'b0001 << ExMem_ALUOut[1:0] :
            ExMem_size == 2'b01 ? (ExMem_ALUOut[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_nx = ExMem_size == 2'b00 ? {4{ExMem_writeData[7:0]}} :
               ExMem_size == 2'b01 ? {2{ExMem_writeData[15:0]}} : ExMem_writeData;
  end
  // MemWB_ALUOut keeps the accepted address through ACCESS, so its low bits pick the load lane
  always_comb begin
    ld_byte = dmem_rdata[{MemWB_ALUOut[1:0], 3'b000} +: 8];
    ld_half = MemWB_ALUOut[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_data = l_size == 2'b00 ? {{24{~l_uns & ld_byte[7]}}, ld_byte} :
              l_size == 2'b01 ? {{16{~l_uns & ld_half[15]}}, ld_half} : dmem_rdata;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      dmem_req <= 1'b0;
      dmem_we <= 1'b0;
      dmem_addr <= '0;
      dmem_be <= '0;
      dmem_wdata <= '0;
      l_size <= '0;
      l_uns <= 1'b0;
      MemWB_valid <= 1'b0;
      MemWB_RegWrite <= 1'b0;
      MemWB_WB_MemToReg <= 1'b0;
      MemWB_rd <= '0;
      MemWB_ALUOut <= '0;
      MemWB_readData <= '0;
    end else if (state == IDLE) begin
      MemWB_valid <= ExMem_valid & ~mem_op;
      MemWB_RegWrite <= ExMem_RegWrite & ~mem_misalign;
      MemWB_WB_MemToReg <= ExMem_MemToReg;
      MemWB_rd <= ExMem_rd;
      MemWB_ALUOut <= ExMem_ALUOut;
      MemWB_readData <= '0;
      if (mem_op & aligned) begin
        dmem_req <= 1'b1;
        dmem_we <= ExMem_MemWrite;
        dmem_addr <= {ExMem_ALUOut[ADDR_W-1:2], 2'b00};
        dmem_be <= be_nx;
        dmem_wdata <= wdata_nx;
        l_size <= ExMem_size;
        l_uns <= ExMem_unsigned;
      end
    end else if (dmem_ack) begin
      dmem_req <= 1'b0;
      MemWB_valid <= 1'b1;
      MemWB_readData <= dmem_we ? '0 : ld_data;
    end else begin
      MemWB_valid <= 1'b0;
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage covering ALU pass-through, sized loads/stores, misalign and reset
module tb_mem_stage;
  logic clk = 1'b0, rst_n = 1'b0;
  logic ExMem_valid = 1'b0, ExMem_RegWrite = 1'b0, ExMem_MemToReg = 1'b0, ExMem_MemRead = 1'b0;
  logic ExMem_MemWrite = 1'b0, ExMem_unsigned = 1'b0;
  logic [31:0] ExMem_ALUOut = '0, ExMem_writeData = '0;
  logic [4:0] ExMem_rd = '0;
  logic [1:0] ExMem_size = '0;
  logic dmem_req, dmem_we, dmem_ack = 1'b0, mem_stall, mem_misalign;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0] dmem_be;
  logic MemWB_valid, MemWB_RegWrite, MemWB_WB_MemToReg;
  logic [4:0] MemWB_rd;
  logic [31:0] MemWB_ALUOut, MemWB_readData;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ExMem_valid(ExMem_valid), .ExMem_ALUOut(ExMem_ALUOut),
    .ExMem_writeData(ExMem_writeData), .ExMem_rd(ExMem_rd), .ExMem_RegWrite(ExMem_RegWrite),
    .ExMem_MemToReg(ExMem_MemToReg), .ExMem_MemRead(ExMem_MemRead), .ExMem_MemWrite(ExMem_MemWrite),
    .ExMem_size(ExMem_size), .ExMem_unsigned(ExMem_unsigned), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack), .mem_stall(mem_stall), .mem_misalign(mem_misalign), .MemWB_valid(MemWB_valid),
    .MemWB_RegWrite(MemWB_RegWrite), .MemWB_WB_MemToReg(MemWB_WB_MemToReg), .MemWB_rd(MemWB_rd),
    .MemWB_ALUOut(MemWB_ALUOut), .MemWB_readData(MemWB_readData)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] rd; logic [31:0] alu; logic [31:0] rdat; logic m2r; logic rw;} wb_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wd;} rq_t;
  wb_t sq[$];
  rq_t rq[$];
  int checks = 0, errors = 0;
  int lat = 0;
  logic [31:0] rd_val = '0;
  logic force_ack = 1'b0;
  logic [4:0] rdn = 5'd10;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // memory model: checks each new request, acks after lat extra cycles, garbage rdata otherwise
  initial begin
    int cnt;
    rq_t r;
    cnt = 0;
    forever begin
      @(negedge clk);
      dmem_ack = force_ack;
      dmem_rdata = 32'h5A5A5A5A;
      if (!dmem_req) cnt = 0;
      else begin
        if (cnt == 0) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got addr %h want no request", dmem_addr);
          end else begin
            r = rq.pop_front();
            chk("req_we", 32'(dmem_we), 32'(r.we));
            chk("req_addr", dmem_addr, r.addr);
            chk("req_be", 32'(dmem_be), 32'(r.be));
            chk("req_wdata", dmem_wdata, r.wd);
          end
        end
        if (cnt == lat) begin
          dmem_ack = 1'b1;
          dmem_rdata = rd_val;
        end
        cnt++;
      end
    end
  end

  initial begin
    wb_t e;
    forever begin
      @(posedge clk);
      #1;
      if (MemWB_valid) begin
        if (sq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got rd %0d alu %h want no valid", MemWB_rd, MemWB_ALUOut);
        end else begin
          e = sq.pop_front();
          chk("wb_rd", 32'(MemWB_rd), 32'(e.rd));
          chk("wb_alu", MemWB_ALUOut, e.alu);
          chk("wb_rdata", MemWB_readData, e.rdat);
          chk("wb_m2r", 32'(MemWB_WB_MemToReg), 32'(e.m2r));
          chk("wb_rw", 32'(MemWB_RegWrite), 32'(e.rw));
        end
      end
    end
  end

  task automatic drive(input logic vld, input logic [31:0] alu, wd, input logic [4:0] rd,
                       input logic rw, m2r, mr, mw, input logic [1:0] sz, input logic uns);
    ExMem_valid = vld; ExMem_ALUOut = alu; ExMem_writeData = wd; ExMem_rd = rd;
    ExMem_RegWrite = rw; ExMem_MemToReg = m2r; ExMem_MemRead = mr; ExMem_MemWrite = mw;
    ExMem_size = sz; ExMem_unsigned = uns;
  endtask

  task automatic op(input logic [31:0] alu, wd, input logic [4:0] rd, input logic rw, m2r, mr, mw,
                    input logic [1:0] sz, input logic uns, output int st, output logic mis, v, w);
    logic s, done;
    @(negedge clk);
    drive(1'b1, alu, wd, rd, rw, m2r, mr, mw, sz, uns);
    st = 0; mis = 1'b0; done = 1'b0;
    for (int n = 0; n < 60 && !done; n++) begin
      #1;
      s = mem_stall;
      mis = mis | mem_misalign;
      if (s) st++;
      @(posedge clk);
      if (!s) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: got stall after 60 cycles want release, rd %0d", rd);
    end
    #1;
    v = MemWB_valid;
    w = MemWB_RegWrite;
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
  endtask

  task automatic ld(input logic [31:0] a, input logic [1:0] sz, input logic u, input logic [3:0] be,
                    input logic [31:0] rdv, input int lt, input logic [31:0] want);
    int st;
    logic mis, v, w;
    rq_t r;
    wb_t e;
    lat = lt; rd_val = rdv; rdn = rdn + 5'd1;
    r.we = 1'b0; r.addr = {a[31:2], 2'b00}; r.be = be; r.wd = '0;
    rq.push_back(r);
    e.rd = rdn; e.alu = a; e.rdat = want; e.m2r = 1'b1; e.rw = 1'b1;
    sq.push_back(e);
    op(a, '0, rdn, 1'b1, 1'b1, 1'b1, 1'b0, sz, u, st, mis, v, w);
    chk("ld_stall_cycles", 32'(st), 32'(lt + 1));
  endtask

  task automatic store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] wexp, input int lt);
    int st;
    logic mis, v, w;
    rq_t r;
    wb_t e;
    lat = lt; rd_val = 32'hDEADDEAD; rdn = rdn + 5'd1;
    r.we = 1'b1; r.addr = {a[31:2], 2'b00}; r.be = be; r.wd = wexp;
    rq.push_back(r);
    e.rd = rdn; e.alu = a; e.rdat = '0; e.m2r = 1'b0; e.rw = 1'b0;
    sq.push_back(e);
    op(a, wd, rdn, 1'b0, 1'b0, 1'b0, 1'b1, sz, 1'b0, st, mis, v, w);
    chk("st_stall_cycles", 32'(st), 32'(lt + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    int st;
    logic mis, v, w;
    wb_t e;
    rq_t r;
    @(negedge clk);
    drive(1'b1, 32'h100, '0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    #1 chk("rst_stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    drive(1'b1, 32'h102, '0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    #1 chk("rst_misalign", 32'(mem_misalign), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_wdata", dmem_wdata, 32'h0);
    chk("rst_valid", 32'(MemWB_valid), 32'h0);
    chk("rst_rw", 32'(MemWB_RegWrite), 32'h0);
    chk("rst_m2r", 32'(MemWB_WB_MemToReg), 32'h0);
    chk("rst_rd", 32'(MemWB_rd), 32'h0);
    chk("rst_alu", MemWB_ALUOut, 32'h0);
    chk("rst_rdata", MemWB_readData, 32'h0);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b1;

    e.rd = 5'd5; e.alu = 32'h1234; e.rdat = '0; e.m2r = 1'b0; e.rw = 1'b1;
    sq.push_back(e);
    op(32'h1234, '0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, st, mis, v, w);
    chk("alu_stall", 32'(st), 32'h0);
    chk("alu_valid", 32'(v), 32'h1);

    ld(32'h100, 2'b10, 1'b0, 4'b1111, 32'hDEADBEEF, 3, 32'hDEADBEEF);
    ld(32'h103, 2'b00, 1'b0, 4'b1000, 32'h80FF0011, 0, 32'hFFFFFF80);
    ld(32'h103, 2'b00, 1'b1, 4'b1000, 32'h80FF0011, 0, 32'h00000080);
    ld(32'h102, 2'b01, 1'b0, 4'b1100, 32'h80FF0011, 1, 32'hFFFF80FF);
    ld(32'h100, 2'b01, 1'b1, 4'b0011, 32'h80FF8011, 0, 32'h00008011);
    ld(32'h101, 2'b00, 1'b0, 4'b0010, 32'h80FF0011, 2, 32'h00000000);
    store(32'h101, 2'b00, 32'h000000AB, 4'b0010, 32'hABABABAB, 0);
    store(32'h102, 2'b01, 32'h00001234, 4'b1100, 32'h12341234, 1);
    store(32'h104, 2'b10, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 2);

    op(32'h102, '0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, st, mis, v, w);
    chk("mis_lw_pulse", 32'(mis), 32'h1);
    chk("mis_lw_stall", 32'(st), 32'h0);
    chk("mis_lw_valid", 32'(v), 32'h0);
    chk("mis_lw_rw", 32'(w), 32'h0);
    #1 chk("mis_lw_req", 32'(dmem_req), 32'h0);
    op(32'h101, '0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, st, mis, v, w);
    chk("mis_lh_pulse", 32'(mis), 32'h1);
    chk("mis_lh_rw", 32'(w), 32'h0);

    lat = 20;
    r.we = 1'b0; r.addr = 32'h200; r.be = 4'b1111; r.wd = '0;
    rq.push_back(r);
    @(negedge clk);
    drive(1'b1, 32'h200, '0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    #1 chk("acc_stall", 32'(mem_stall), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    force_ack = 1'b1;
    #1 chk("acc_rst_stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("acc_rst_req", 32'(dmem_req), 32'h0);
    chk("acc_rst_addr", dmem_addr, 32'h0);
    chk("acc_rst_be", 32'(dmem_be), 32'h0);
    chk("acc_rst_valid", 32'(MemWB_valid), 32'h0);
    chk("acc_rst_rd", 32'(MemWB_rd), 32'h0);
    chk("acc_rst_alu", MemWB_ALUOut, 32'h0);
    chk("acc_rst_idle_ack_stall", 32'(mem_stall), 32'h0);
    @(negedge clk);
    force_ack = 1'b0;
    #1 chk("late_ack_req", 32'(dmem_req), 32'h0);
    ld(32'h204, 2'b10, 1'b0, 4'b1111, 32'h0BADF00D, 1, 32'h0BADF00D);

    repeat (5) @(negedge clk);
    chk("sq_drained", 32'(sq.size()), 32'h0);
    chk("rq_drained", 32'(rq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
